// File: rtl/reg_window_ctrl_pkg.sv
// reg_window_ctrl_pkg: shared window geometry and controller state encoding.
package reg_window_ctrl_pkg;
   localparam int WIN_BITS     = 2;
   localparam int NREG_PHYS    = 8;
   localparam int WIN_STRIDE   = 2;
   localparam int MAX_RESIDENT = 3;
   typedef enum logic [2:0] {IDLE, SPILL0, SPILL1, FILL0, FILL1} state_t;
endpackage

// File: rtl/reg_window_ctrl.sv
// reg_window_ctrl: register-window pointer manager with spill/fill to a memory stack.
module reg_window_ctrl
   import reg_window_ctrl_pkg::*;
#(
   parameter int                DATA_W     = 16,
   parameter int                ADDR_W     = 16,
   parameter logic [ADDR_W-1:0] STACK_BASE = 'h0100,
   parameter int                MAX_SPILL  = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                call,
   input  logic                ret,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic [WIN_BITS-1:0] cwp,
   output logic [WIN_BITS-1:0] rf_wnd,
   output logic [1:0]          rf_reg,
   output logic                rf_wen,
   output logic [DATA_W-1:0]   rf_wdata,
   input  logic [DATA_W-1:0]   rf_rdata,
   output logic                rf_ldwnd,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                mem_rd,
   output logic                mem_wr,
   input  logic                mem_ready
);
   localparam int DEPTH_W = $clog2(MAX_SPILL + 1);
   localparam logic [ADDR_W-1:0] SP_STEP = ADDR_W'(WIN_STRIDE);
   localparam logic [WIN_BITS-1:0] W_ONE = WIN_BITS'(1);

   state_t              r_state;
   logic [WIN_BITS-1:0] r_cwp;
   logic [WIN_BITS-1:0] r_owp;
   logic [DEPTH_W-1:0]  r_depth;
   logic [ADDR_W-1:0]   r_sp;
   logic                r_done;
   logic                r_err;
   logic                r_ldwnd;

   logic [WIN_BITS-1:0] w_diff;
   logic                w_full;
   logic                w_single;
   logic                w_spill;
   logic                w_fill;
   logic                w_k;

   // resident windows minus one; full means the next call would clobber owp
   assign w_diff   = r_cwp - r_owp;
   assign w_full   = w_diff == WIN_BITS'(MAX_RESIDENT - 1);
   assign w_single = w_diff == '0;
   assign w_spill  = r_state == SPILL0 || r_state == SPILL1;
   assign w_fill   = r_state == FILL0 || r_state == FILL1;
   assign w_k      = r_state == SPILL1 || r_state == FILL1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cwp   <= '0;
         r_owp   <= '0;
         r_depth <= '0;
         r_sp    <= STACK_BASE;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_ldwnd <= 1'b0;
      end else begin
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_ldwnd <= 1'b0;
         case (r_state)
            IDLE: begin
               if (call && ret) begin
                  r_err <= 1'b1;
               end else if (call) begin
                  if (!w_full) begin
                     r_cwp   <= r_cwp + W_ONE;
                     r_done  <= 1'b1;
                     r_ldwnd <= 1'b1;
                  end else if (r_depth == DEPTH_W'(MAX_SPILL)) begin
                     r_err <= 1'b1;
                  end else begin
                     r_state <= SPILL0;
                  end
               end else if (ret) begin
                  if (!w_single) begin
                     r_cwp   <= r_cwp - W_ONE;
                     r_done  <= 1'b1;
                     r_ldwnd <= 1'b1;
                  end else if (r_depth == '0) begin
                     r_err <= 1'b1;
                  end else begin
                     r_state <= FILL0;
                  end
               end
            end
            SPILL0: if (mem_ready) r_state <= SPILL1;
            FILL0:  if (mem_ready) r_state <= FILL1;
            SPILL1: begin
               if (mem_ready) begin
                  r_state <= IDLE;
                  r_sp    <= r_sp + SP_STEP;
                  r_depth <= r_depth + DEPTH_W'(1);
                  r_owp   <= r_owp + W_ONE;
                  r_cwp   <= r_cwp + W_ONE;
                  r_done  <= 1'b1;
                  r_ldwnd <= 1'b1;
               end
            end
            FILL1: begin
               if (mem_ready) begin
                  r_state <= IDLE;
                  r_sp    <= r_sp - SP_STEP;
                  r_depth <= r_depth - DEPTH_W'(1);
                  r_owp   <= r_owp - W_ONE;
                  r_cwp   <= r_cwp - W_ONE;
                  r_done  <= 1'b1;
                  r_ldwnd <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // spill drains the oldest window; fill restores the one just below it
   always_comb begin
      busy      = r_state != IDLE;
      done      = r_done;
      err       = r_err;
      rf_ldwnd  = r_ldwnd;
      cwp       = r_cwp;
      rf_wnd    = w_spill ? r_owp : w_fill ? r_owp - W_ONE : r_cwp;
      rf_reg    = {1'b0, w_k};
      mem_addr  = w_spill ? r_sp + ADDR_W'(w_k) : w_fill ? r_sp - SP_STEP + ADDR_W'(w_k) : r_sp;
      mem_wr    = w_spill;
      mem_rd    = w_fill;
      mem_wdata = rf_rdata;
      rf_wen    = w_fill && mem_ready;
      rf_wdata  = mem_rdata;
   end
endmodule
